// File: rtl/mips_pkg.sv
// Shared write-back / register-file constants: WBreg bit positions, the
// hardwired zero register index and the default datapath widths.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_core.sv
// Architectural register storage: one synchronous write port, two combinational
// read ports and a registered debug port, with register 0 reading as zero.
module regfile_core #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [1:0][ADDR_W-1:0] raddr,
  output logic [1:0][DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0]      dbg_addr,
  output logic [DATA_W-1:0]      dbg_data
);
  import mips_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [DEPTH];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      dbg_data <= '0;
    end else begin
      if (we && (waddr != ZERO_IDX)) begin
        regs[waddr] <= wdata;
      end
      dbg_data <= (dbg_addr == ZERO_IDX) ? '0 : regs[dbg_addr];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rdata[gi] = (raddr[gi] == ZERO_IDX) ? '0 : regs[raddr[gi]];
    end
  endgenerate
endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects load data or ALU result, commits it to the register
// file, bypasses it to same-cycle ID reads and counts committed writes.
module wb_regfile_stage #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        WBreg,
  input  logic [DATA_W-1:0] Memreg,
  input  logic [DATA_W-1:0] ALUreg,
  input  logic [ADDR_W-1:0] RegRDreg,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  wr_count
);
  import mips_pkg::*;

  logic                   commit;
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] core_data;
  logic [1:0][DATA_W-1:0] port_data;

  assign wb_data = WBreg[WB_MEMTOREG] ? Memreg : ALUreg;
  // Reset gates the commit, which also turns off the bypass during reset.
  assign commit  = reset_n && WBreg[WB_REGWRITE] && (RegRDreg != ADDR_W'(REG_ZERO));

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;

  regfile_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (commit),
    .waddr   (RegRDreg),
    .wdata   (wb_data),
    .raddr   (rd_addr),
    .rdata   (core_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_byp
      assign port_data[gi] = (commit && (rd_addr[gi] == RegRDreg)) ? wb_data : core_data[gi];
    end
  endgenerate

  assign rs_data = port_data[0];
  assign rt_data = port_data[1];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_count <= '0;
    end else if (commit) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Scoreboard bench: the driver pushes expected outputs per cycle from a
// behavioural register-file model; a negedge monitor pops and compares them.
module tb_wb_regfile_stage;
  localparam int CW = 8;

  logic          clock;
  logic          reset_n;
  logic [1:0]    WBreg;
  logic [31:0]   Memreg, ALUreg;
  logic [4:0]    RegRDreg, rs_addr, rt_addr, dbg_addr;
  logic [31:0]   rs_data, rt_data, wb_data, dbg_data;
  logic [CW-1:0] wr_count;

  wb_regfile_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .WBreg(WBreg), .Memreg(Memreg), .ALUreg(ALUreg),
    .RegRDreg(RegRDreg), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .wb_data(wb_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .wr_count(wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  localparam int S_RS = 0, S_RT = 1, S_WB = 2, S_DBG = 3, S_CNT = 4;

  exp_t        q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference model: architectural register contents and observable state.
  logic [31:0]   m_regs [32];
  logic [CW-1:0] m_cnt;
  logic [31:0]   m_dbg;

  function automatic string sig_name(input int s);
    case (s)
      S_RS:    return "rs_data";
      S_RT:    return "rt_data";
      S_WB:    return "wb_data";
      S_DBG:   return "dbg_data";
      default: return "wr_count";
    endcase
  endfunction

  function automatic logic [31:0] sample(input int s);
    case (s)
      S_RS:    return rs_data;
      S_RT:    return rt_data;
      S_WB:    return wb_data;
      S_DBG:   return dbg_data;
      default: return 32'(wr_count);
    endcase
  endfunction

  task automatic push(input int s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.sig = s;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic [1:0] wb, input logic [31:0] mem,
                      input logic [31:0] alu, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] dbga);
    logic [31:0] wbv;
    logic        commit;
    @(posedge clock);
    #1;
    cyc++;
    reset_n = rst; WBreg = wb; Memreg = mem; ALUreg = alu;
    RegRDreg = rd; rs_addr = rs; rt_addr = rt; dbg_addr = dbga;
    $display("step %0d rst_n=%b wb=%b rd=%0d rs=%0d rt=%0d dbg=%0d", cyc, rst, wb, rd, rs, rt, dbga);
    wbv    = wb[0] ? mem : alu;
    commit = rst && wb[1] && (rd != 5'd0);
    push(S_WB, wbv);
    push(S_RS, (commit && rs == rd) ? wbv : m_regs[rs]);
    push(S_RT, (commit && rt == rd) ? wbv : m_regs[rt]);
    push(S_DBG, m_dbg);
    push(S_CNT, 32'(m_cnt));
    // State after the coming edge.
    if (!rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_cnt = '0;
      m_dbg = '0;
    end else begin
      m_dbg = m_regs[dbga];
      if (commit) begin
        m_regs[rd] = wbv;
        m_cnt = m_cnt + 1'b1;
      end
    end
  endtask

  // Monitor: compares every expectation tagged with the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clock);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        n_checks++;
        act = sample(e.sig);
        if (e.cyc != cyc) begin
          $display("FAIL stale_%s cyc=%0d expected=%h never checked", sig_name(e.sig), e.cyc, e.exp);
        end else if (act === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s cyc=%0d actual=%h expected=%h", sig_name(e.sig), cyc, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [4:0] rd, rs, rt;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_cnt = '0;
    m_dbg = '0;
    // Reset inputs at time 0, so the first edge already clears the array.
    reset_n = 1'b0; WBreg = 2'b10; Memreg = '0; ALUreg = 32'hDEAD;
    RegRDreg = 5'd5; rs_addr = 5'd5; rt_addr = 5'd5; dbg_addr = 5'd5;

    // Reset held two cycles with a write to r5 pending.
    step(0, 2'b10, 0, 32'hDEAD, 5, 5, 5, 5);
    step(0, 2'b10, 0, 32'hDEAD, 5, 5, 5, 5);
    push(S_RS, 32'h0); push(S_CNT, 32'h0); push(S_DBG, 32'h0);
    step(1, 2'b00, 0, 32'hDEAD, 5, 5, 5, 5);
    push(S_RS, 32'h0); push(S_CNT, 32'h0); push(S_DBG, 32'h0);

    // ALU write to r8.
    step(1, 2'b10, 32'h0, 32'h1234_5678, 8, 0, 0, 0);
    push(S_WB, 32'h1234_5678);
    step(1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 8);
    push(S_CNT, 32'd1);
    step(1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 8);
    push(S_DBG, 32'h1234_5678);

    // Load write to r9.
    step(1, 2'b11, 32'hCAFE_F00D, 32'h1, 9, 9, 9, 0);
    push(S_WB, 32'hCAFE_F00D); push(S_RS, 32'hCAFE_F00D);
    step(1, 2'b00, 32'h0, 32'h0, 0, 9, 0, 0);
    push(S_RS, 32'hCAFE_F00D); push(S_CNT, 32'd2);

    // Write to r0 is dropped.
    step(1, 2'b10, 32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    push(S_RS, 32'h0); push(S_WB, 32'hFFFF_FFFF);
    step(1, 2'b00, 32'h0, 32'h0, 0, 0, 0, 0);
    push(S_RS, 32'h0); push(S_CNT, 32'd2);

    // Bypass on r3, then the same stimulus without RegWrite.
    step(1, 2'b10, 32'h0, 32'h11, 3, 0, 0, 0);
    step(1, 2'b10, 32'h0, 32'h22, 3, 3, 3, 0);
    push(S_RS, 32'h22); push(S_RT, 32'h22);
    step(1, 2'b00, 32'h0, 32'h0, 0, 3, 3, 0);
    push(S_RS, 32'h22); push(S_RT, 32'h22);
    step(1, 2'b10, 32'h0, 32'h11, 3, 0, 0, 0);
    step(1, 2'b00, 32'h0, 32'h22, 3, 3, 3, 0);
    push(S_RS, 32'h11); push(S_RT, 32'h11);
    step(1, 2'b00, 32'h0, 32'h0, 0, 3, 3, 0);
    push(S_RS, 32'h11);

    // Reset mid-stream with a write to r4 pending.
    for (int i = 1; i <= 4; i++) step(1, 2'b10, 32'h0, 32'h100 + 32'(i), 5'(i), 0, 0, 0);
    step(0, 2'b10, 32'h0, 32'h44, 4, 4, 4, 4);
    step(1, 2'b10, 32'h0, 32'h77, 1, 2, 4, 4);
    push(S_CNT, 32'd0); push(S_DBG, 32'h0); push(S_RS, 32'h0); push(S_RT, 32'h0);
    step(1, 2'b00, 32'h0, 32'h0, 0, 1, 3, 2);
    push(S_CNT, 32'd1); push(S_RS, 32'h77); push(S_RT, 32'h0);

    // Randomized traffic biased toward address collisions; the narrow counter wraps.
    for (int n = 0; n < 400; n++) begin
      rd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
           rd, rs, rt, 5'($urandom_range(0, 31)));
    end

    repeat (2) @(negedge clock);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
